store_buffer_unit: RTL and testbench
====================================

// Module: store_buffer_unit
// PURPOSE
//  Parametrised store path between the CPU execute/memory stage and the data-memory write port.
//  Per store: legal-op and alignment check, byte-lane placement from address bits [1:0],
//  byte-enable generation, then queueing in a DEPTH-entry FIFO.
//  Drains to memory over a waitrequest handshake, so the core does not stall on slow writes.
//  Optional write-combining merges consecutive stores to the same word.
// PARAMETERS
//  ADDR_W   32  byte-address width
//  DEPTH    4   FIFO entries, power of two, >=2
//  MERGE    1   1 = combine a store into the tail entry when word addresses match
// PORTS
//  clk              in   1               rising-edge clock
//  reset_n          in   1               asynchronous, active-low reset
//  st_valid         in   1               store request valid
//  st_ready         out  1               buffer can accept (= !full)
//  st_op            in   6               MIPS opcode: 101000 SB, 101001 SH, 101011 SW
//  st_addr          in   ADDR_W          byte address
//  st_data          in   32              rt register value, low bits significant for SB/SH
//  st_fault         out  1               one-cycle pulse: last accepted request was illegal or misaligned
//  mem_address      out  ADDR_W          word address of head entry, bits [1:0]=00
//  mem_write        out  1               head entry valid (= !empty)
//  mem_writedata    out  32              lane-placed data of head entry
//  mem_byteenable   out  4               byte enables of head entry
//  mem_waitrequest  in   1               memory stall; head is held while high
//  empty            out  1               no pending stores
//  count            out  $clog2(DEPTH)+1 occupied entries
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - count=0, empty=1, mem_write=0, st_fault=0; pointers cleared.
//   - All pending entries are discarded, including one mid-handshake.
//  Accept: st_valid & st_ready. Requests presented while st_ready=0 are not sampled.
//  Lane rules, little-endian, lane k = bits [8k+7:8k], a = st_addr[1:0]:
//   - SB: any a. data = {4{st_data[7:0]}}, be = 4'b0001<<a.
//   - SH: a[0] must be 0. data = {2{st_data[15:0]}}, be = 4'b0011<<a.
//   - SW: a must be 00. data = st_data, be = 4'b1111.
//  Fault:
//   - Accepted request that is misaligned or carries any other opcode is consumed but not queued.
//   - st_fault=1 on the following cycle only. Queue and count are unaffected.
//  Enqueue: the entry holds {st_addr[ADDR_W-1:2],2'b00}, data, be.
//   - Visible on the mem_* outputs no earlier than the cycle after acceptance (no bypass).
//  Drain: mem_write=!empty and the head is presented.
//   - Pop when mem_write & !mem_waitrequest.
//   - mem_address, mem_writedata and mem_byteenable stay stable while mem_waitrequest=1.
//  Merge (MERGE=1):
//   - Condition: legal store, count>=2, and tail word address == new word address.
//   - Tail be |= new be; the lanes selected by new be are overwritten in tail data.
//   - count is unchanged.
//   - Merging into the head is never allowed, even at count==1.
//  Simultaneous push and pop: count unchanged, order preserved.
//   - A merge together with a pop: count decrements by 1.
//  Full: count==DEPTH -> st_ready=0. A pop in the same cycle does not raise st_ready combinationally.
//  Pointers wrap modulo DEPTH. The count width distinguishes full from empty.
//  Stores drain strictly in acceptance order. Loads are not checked against the queue.
// TESTING
//  1. SB 0x...AB at addr 0x1003, no wait -> next cycle mem_write=1, addr 0x1000, be 1000,
//     data 0xABABABAB; popped the same cycle.
//  2. SH addr 0x2001 -> not queued, st_fault=1 for exactly one cycle, count stays 0;
//     same for opcode 100011.
//  3. Hold mem_waitrequest=1, issue 4 SWs to distinct words -> count=4, st_ready=0,
//     a 5th request is not accepted; release -> 4 writes drained in order, count=0.
//  4. MERGE=1, waitrequest=1: SW 0x11111111@0x10, SB 0x22@0x20, SB 0x33@0x21
//     -> count=2, second entry be 0011, data[15:0]=0x3322.
//  5. Assert reset_n=0 mid-drain with count=3 -> mem_write=0 and count=0 immediately, no further writes.
//  6. At count=DEPTH-1, push and pop in the same cycle for 2*DEPTH cycles
//     -> count constant, data order intact across pointer wrap.

Source files
------------

// File: rtl/store_buffer_unit.sv
// Store path from the execute/memory stage to the data-memory write port:
// lane placement, fault detection, optional write-combining, and a DEPTH-entry drain FIFO.
module store_buffer_unit #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter bit MERGE  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [5:0]               st_op,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [31:0]              st_data,
  output logic                     st_fault,
  output logic [ADDR_W-1:0]        mem_address,
  output logic                     mem_write,
  output logic [31:0]              mem_writedata,
  output logic [3:0]               mem_byteenable,
  input  logic                     mem_waitrequest,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_W - 2;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  logic [WW-1:0] addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    be_mem   [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] last;

  logic          legal;
  logic [31:0]   lane_data;
  logic [3:0]    lane_be;
  logic [WW-1:0] word;
  logic          accept;
  logic          pop;
  logic          do_merge;
  logic          push;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_data;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) res[8*k +: 8] = new_data[8*k +: 8];
    end
    return res;
  endfunction

  always_comb begin
    legal     = 1'b0;
    lane_data = st_data;
    lane_be   = 4'b0000;
    case (st_op)
      OP_SB: begin
        legal     = 1'b1;
        lane_data = {4{st_data[7:0]}};
        lane_be   = 4'b0001 << st_addr[1:0];
      end
      OP_SH: begin
        legal     = ~st_addr[0];
        lane_data = {2{st_data[15:0]}};
        lane_be   = 4'b0011 << st_addr[1:0];
      end
      OP_SW: begin
        legal     = (st_addr[1:0] == 2'b00);
        lane_data = st_data;
        lane_be   = 4'b1111;
      end
      default: ;
    endcase
  end

  assign word   = st_addr[ADDR_W-1:2];
  assign last   = tail - PW'(1);
  assign accept = st_valid & st_ready;
  assign pop    = mem_write & ~mem_waitrequest;

  // Merging needs count>=2 so the tail is never the head being presented to memory.
  assign do_merge = MERGE && accept && legal && (count >= CW'(2)) && (addr_mem[last] == word);
  assign push     = accept & legal & ~do_merge;

  // Full is judged from the registered count, so a same-cycle pop never raises st_ready.
  assign st_ready       = (count != CW'(DEPTH));
  assign empty          = (count == '0);
  assign mem_write      = ~empty;
  assign mem_address    = {addr_mem[head], 2'b00};
  assign mem_writedata  = data_mem[head];
  assign mem_byteenable = be_mem[head];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      st_fault <= 1'b0;
    end else begin
      st_fault <= accept & ~legal;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= word;
      data_mem[tail] <= lane_data;
      be_mem[tail]   <= lane_be;
    end
    if (do_merge) begin
      data_mem[last] <= merge_lanes(data_mem[last], lane_data, lane_be);
      be_mem[last]   <= be_mem[last] | lane_be;
    end
  end

endmodule

// File: tb/tb_store_buffer_unit.sv
// Bench for store_buffer_unit: directed scenarios plus random traffic against a queue-based model.
module tb_store_buffer_unit;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam bit MERGE  = 1'b1;
  localparam int CW     = $clog2(DEPTH) + 1;

  localparam logic [5:0] SB = 6'b101000;
  localparam logic [5:0] SH = 6'b101001;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] LW = 6'b100011;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              st_valid = 1'b0;
  logic              st_ready;
  logic [5:0]        st_op = '0;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [31:0]       st_data = '0;
  logic              st_fault;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [3:0]        mem_byteenable;
  logic              mem_waitrequest = 1'b0;
  logic              empty;
  logic [CW-1:0]     count;

  typedef struct {
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       data;
    logic [3:0]        be;
  } entry_t;

  entry_t q[$];
  bit     exp_fault = 1'b0;
  int     n_vec = 0;
  int     n_fail = 0;

  store_buffer_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MERGE(MERGE)) dut (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data), .st_fault(st_fault),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [5:0] op, input logic [ADDR_W-1:0] a,
                       input logic [31:0] d, output bit legal, output entry_t e);
    int sz;
    int off;
    off     = int'(a[1:0]);
    e.waddr = {a[ADDR_W-1:2], 2'b00};
    e.be    = 4'b0000;
    legal   = 1'b1;
    case (op)
      SB: begin sz = 1; e.data = {4{d[7:0]}}; end
      SH: begin sz = 2; e.data = {2{d[15:0]}}; legal = (off % 2 == 0); end
      SW: begin sz = 4; e.data = d; legal = (off == 0); end
      default: begin sz = 0; e.data = d; legal = 1'b0; end
    endcase
    for (int i = 0; i < sz; i++) begin
      if (off + i < 4) e.be[off + i] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("mem_write", 64'(mem_write), 64'(q.size() != 0));
    chk("st_ready", 64'(st_ready), 64'(q.size() < DEPTH));
    chk("st_fault", 64'(st_fault), 64'(exp_fault));
    if (q.size() > 0) begin
      chk("mem_address", 64'(mem_address), 64'(q[0].waddr));
      chk("mem_writedata", 64'(mem_writedata), 64'(q[0].data));
      chk("mem_byteenable", 64'(mem_byteenable), 64'(q[0].be));
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    bit     acc;
    bit     pop;
    bit     legal;
    bit     merge;
    entry_t e;
    entry_t t;
    acc       = st_valid && (q.size() < DEPTH);
    pop       = (q.size() > 0) && !mem_waitrequest;
    legal     = 1'b0;
    exp_fault = 1'b0;
    if (acc) begin
      build(st_op, st_addr, st_data, legal, e);
      exp_fault = !legal;
    end
    merge = acc && legal && MERGE && (q.size() >= 2) && (q[q.size()-1].waddr == e.waddr);
    if (merge) begin
      t = q[q.size()-1];
      for (int k = 0; k < 4; k++) begin
        if (e.be[k]) t.data[8*k +: 8] = e.data[8*k +: 8];
      end
      t.be = t.be | e.be;
      q[q.size()-1] = t;
    end
    if (pop) void'(q.pop_front());
    if (acc && legal && !merge) q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input bit v, input logic [5:0] op,
                        input logic [ADDR_W-1:0] a, input logic [31:0] d);
    st_valid = v;
    st_op    = op;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    // reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_st_fault", 64'(st_fault), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    // single SB, no wait: visible next cycle, popped the same cycle
    mem_waitrequest = 1'b0;
    set_st(1, SB, 32'h1003, 32'h000000AB);
    step();
    set_st(0, SB, 32'h0, 32'h0);
    chk("t1_addr", 64'(mem_address), 64'h1000);
    step();
    step();

    // faults: misaligned SH, then a non-store opcode
    set_st(1, SH, 32'h2001, 32'h1234);
    step();
    set_st(0, SB, 32'h0, 32'h0);
    step();
    step();
    set_st(1, LW, 32'h2000, 32'h5678);
    step();
    set_st(0, SB, 32'h0, 32'h0);
    step();
    step();

    // fill under waitrequest, 5th request refused, then drain in order
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_st(1, SW, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i));
      step();
    end
    set_st(1, SW, 32'h200, 32'hDEAD_BEEF);
    step();
    step();
    chk("t3_full_count", 64'(count), 64'(DEPTH));
    set_st(0, SB, 32'h0, 32'h0);
    mem_waitrequest = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // write-combining into the tail entry
    mem_waitrequest = 1'b1;
    set_st(1, SW, 32'h10, 32'h11111111); step();
    set_st(1, SB, 32'h20, 32'h22);       step();
    set_st(1, SB, 32'h21, 32'h33);       step();
    set_st(0, SB, 32'h0, 32'h0);         step();
    chk("t4_merge_count", 64'(count), 64'd2);
    mem_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // asynchronous reset in the middle of a drain
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_st(1, SW, 32'h300 + 32'(i * 4), 32'hC000_0000 + 32'(i));
      step();
    end
    set_st(0, SB, 32'h0, 32'h0);
    step();
    mem_waitrequest = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_mem_write", 64'(mem_write), 64'd0);
    chk("t5_count", 64'(count), 64'd0);
    q.delete();
    exp_fault = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // steady push+pop at DEPTH-1 across pointer wrap
    mem_waitrequest = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      set_st(1, SW, 32'h400 + 32'(i * 4), 32'hB000_0000 + 32'(i));
      step();
    end
    mem_waitrequest = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      set_st(1, SW, 32'h500 + 32'(i * 4), 32'hE000_0000 + 32'(i));
      step();
      chk("t6_count", 64'(count), 64'(DEPTH - 1));
    end
    set_st(0, SB, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 4))
        0: op = SB;
        1: op = SH;
        2, 3: op = SW;
        default: op = LW;
      endcase
      set_st($urandom_range(0, 3) != 0, op,
             32'h4000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
             $urandom);
      mem_waitrequest = ($urandom_range(0, 2) == 0);
      step();
    end
    set_st(0, SB, 32'h0, 32'h0);
    mem_waitrequest = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
